// File: rtl/ps2_keyboard_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scancodes, frame FSM encoding, sizing.
// FIFO sizing exists only when PS2_KEYBOARD_FIFO_EN is defined.
package ps2_keyboard_pkg;

  localparam int unsigned SC_W    = 8;
  localparam int unsigned ASCII_W = 7;

  localparam logic [SC_W-1:0] SC_BREAK  = 8'hF0;
  localparam logic [SC_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [SC_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [SC_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [SC_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [SC_W-1:0] SC_ENTER  = 8'h5A;
  localparam logic [SC_W-1:0] SC_BKSP   = 8'h66;
  localparam logic [SC_W-1:0] SC_ESC    = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

`ifdef PS2_KEYBOARD_FIFO_EN
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = 2;
  localparam int unsigned FIFO_CNT_W = 3;
`endif

  function automatic logic is_letter(input logic [ASCII_W-1:0] c);
    return (c >= 7'h41) && (c <= 7'h5A);
  endfunction

endpackage

// File: rtl/ps2_scancode_rom.sv
// Registered set-2 scancode to Apple1 ASCII lookup; shift acts as the address MSB.
// A zero result marks an unmapped key.
module ps2_scancode_rom
  import ps2_keyboard_pkg::*;
(
  input  logic               clk25,
  input  logic               rst,
  input  logic               shift,
  input  logic [SC_W-1:0]    scancode,
  output logic [ASCII_W-1:0] ascii
);

  logic [ASCII_W-1:0] ascii_d;
  logic [ASCII_W-1:0] ascii_q;

  always_comb begin
    ascii_d = '0;
    case (scancode)
      8'h1C: ascii_d = 7'h41;
      8'h32: ascii_d = 7'h42;
      8'h21: ascii_d = 7'h43;
      8'h23: ascii_d = 7'h44;
      8'h24: ascii_d = 7'h45;
      8'h2B: ascii_d = 7'h46;
      8'h34: ascii_d = 7'h47;
      8'h33: ascii_d = 7'h48;
      8'h43: ascii_d = 7'h49;
      8'h3B: ascii_d = 7'h4A;
      8'h42: ascii_d = 7'h4B;
      8'h4B: ascii_d = 7'h4C;
      8'h3A: ascii_d = 7'h4D;
      8'h31: ascii_d = 7'h4E;
      8'h44: ascii_d = 7'h4F;
      8'h4D: ascii_d = 7'h50;
      8'h15: ascii_d = 7'h51;
      8'h2D: ascii_d = 7'h52;
      8'h1B: ascii_d = 7'h53;
      8'h2C: ascii_d = 7'h54;
      8'h3C: ascii_d = 7'h55;
      8'h2A: ascii_d = 7'h56;
      8'h1D: ascii_d = 7'h57;
      8'h22: ascii_d = 7'h58;
      8'h35: ascii_d = 7'h59;
      8'h1A: ascii_d = 7'h5A;
      // Digits and punctuation: shift picks the symbol row
      8'h45: ascii_d = shift ? 7'h29 : 7'h30;
      8'h16: ascii_d = shift ? 7'h21 : 7'h31;
      8'h1E: ascii_d = shift ? 7'h40 : 7'h32;
      8'h26: ascii_d = shift ? 7'h23 : 7'h33;
      8'h25: ascii_d = shift ? 7'h24 : 7'h34;
      8'h2E: ascii_d = shift ? 7'h25 : 7'h35;
      8'h36: ascii_d = shift ? 7'h5E : 7'h36;
      8'h3D: ascii_d = shift ? 7'h26 : 7'h37;
      8'h3E: ascii_d = shift ? 7'h2A : 7'h38;
      8'h46: ascii_d = shift ? 7'h28 : 7'h39;
      8'h29: ascii_d = 7'h20;
      8'h4E: ascii_d = shift ? 7'h5F : 7'h2D;
      8'h55: ascii_d = shift ? 7'h2B : 7'h3D;
      8'h54: ascii_d = shift ? 7'h7B : 7'h5B;
      8'h5B: ascii_d = shift ? 7'h7D : 7'h5D;
      8'h5D: ascii_d = shift ? 7'h7C : 7'h5C;
      8'h4C: ascii_d = shift ? 7'h3A : 7'h3B;
      8'h52: ascii_d = shift ? 7'h22 : 7'h27;
      8'h41: ascii_d = shift ? 7'h3C : 7'h2C;
      8'h49: ascii_d = shift ? 7'h3E : 7'h2E;
      8'h4A: ascii_d = shift ? 7'h3F : 7'h2F;
      8'h0E: ascii_d = shift ? 7'h7E : 7'h60;
      SC_ENTER: ascii_d = 7'h0D;
      SC_BKSP:  ascii_d = 7'h5F;
      SC_ESC:   ascii_d = 7'h1B;
      default:  ascii_d = '0;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      ascii_q <= '0;
    end else begin
      ascii_q <= ascii_d;
    end
  end

  assign ascii = ascii_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver presenting Apple1 ASCII on a KBD/KBDCR register pair.
// Define PS2_KEYBOARD_FIFO_EN to replace the holding register with a 4-entry FIFO.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       enable,
  input  logic       address,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned SYNC_W    = 3;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_W-1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  frame_state_e         state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SC_W-1:0]      shreg_q, shreg_d;
  logic                 par_ok_q, par_ok_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 brk_q, brk_d, ext_q, ext_d;
  logic                 lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
  logic                 lookup_q, lookup_d, ctrl_lk_q, ctrl_lk_d;
  logic                 rd_seen_q, rd_seen_d;
  logic                 overrun_q, overrun_d;
  logic                 fall_c, bit_c, ack_c, push_c, ready_c;
  logic [ASCII_W-1:0]   rom_ascii_c, char_c, head_c;

  // Sync chain; a falling edge is the older stage high and the newer stage low
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_W-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_W-2:0], ps2_data};
  end
  assign fall_c = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_c  = dat_sync_q[2];

  // Frame FSM with mid-frame timeout
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_ok_d     = par_ok_q;
    tmo_d        = '0;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_c) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {bit_c, shreg_q[SC_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{bit_c, shreg_q};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (bit_c && par_ok_q) byte_valid_d = 1'b1;
          else                   frame_err_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = ST_IDLE;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Make/break/extended tracking and modifier state
  always_comb begin
    brk_d     = brk_q;
    ext_d     = ext_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    ctrl_d    = ctrl_q;
    lookup_d  = 1'b0;
    ctrl_lk_d = ctrl_lk_q;
    if (byte_valid_q) begin
      if (shreg_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        case (shreg_q)
          SC_LSHIFT: lshift_d = ~brk_q;
          SC_RSHIFT: rshift_d = ~brk_q;
          SC_CTRL:   ctrl_d   = ~brk_q;
          default: begin
            lookup_d  = ~brk_q & ~ext_q;
            ctrl_lk_d = ctrl_q;
          end
        endcase
      end
    end
  end

  ps2_scancode_rom u_rom (
    .clk25    (clk25),
    .rst      (rst),
    .shift    (lshift_q | rshift_q),
    .scancode (shreg_q),
    .ascii    (rom_ascii_c)
  );

  assign char_c = (ctrl_lk_q && is_letter(rom_ascii_c)) ? (rom_ascii_c & 7'h1F) : rom_ascii_c;
  assign push_c = lookup_q && (rom_ascii_c != '0);

  // One pop per CPU access: re-armed only once enable drops
  assign ack_c = enable & rd_en & ~address & ~rd_seen_q;
  always_comb begin
    rd_seen_d = rd_seen_q;
    if (!enable)    rd_seen_d = 1'b0;
    else if (ack_c) rd_seen_d = 1'b1;
  end

`ifdef PS2_KEYBOARD_FIFO_EN
  logic [ASCII_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [ASCII_W-1:0]    fifo_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pop_c, wr_c;

  // A full FIFO still accepts a push when a pop lands in the same cycle
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pop_c     = ack_c && (cnt_q != '0);
    wr_c      = push_c && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || pop_c);
    overrun_d = push_c && !wr_c;
    if (wr_c) begin
      fifo_d[wr_ptr_q] = char_c;
      wr_ptr_d         = wr_ptr_q + FIFO_PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
    if (wr_c && !pop_c)      cnt_d = cnt_q + FIFO_CNT_W'(1);
    else if (!wr_c && pop_c) cnt_d = cnt_q - FIFO_CNT_W'(1);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_c  = fifo_q[rd_ptr_q];
  assign ready_c = (cnt_q != '0);
`else
  logic [ASCII_W-1:0] char_q, char_d;
  logic               ready_q, ready_d;
  logic               wr_c;

  // Drop-new holding register; a same-cycle pop frees the slot first
  always_comb begin
    char_d    = char_q;
    ready_d   = ready_q;
    wr_c      = push_c && (!ready_q || ack_c);
    overrun_d = push_c && !wr_c;
    if (wr_c) begin
      char_d  = char_c;
      ready_d = 1'b1;
    end else if (ack_c) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      char_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      char_q  <= char_d;
      ready_q <= ready_d;
    end
  end

  assign head_c  = char_q;
  assign ready_c = ready_q;
`endif

  always_ff @(posedge clk25) begin
    if (rst) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      ctrl_q       <= 1'b0;
      lookup_q     <= 1'b0;
      ctrl_lk_q    <= 1'b0;
      rd_seen_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      ctrl_q       <= ctrl_d;
      lookup_q     <= lookup_d;
      ctrl_lk_q    <= ctrl_lk_d;
      rd_seen_q    <= rd_seen_d;
      overrun_q    <= overrun_d;
    end
  end

  // Read mux; idle bus reads as zero
  always_comb begin
    dout = '0;
    if (rd_en) dout = address ? {ready_c, 7'b0} : {1'b1, head_c};
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus randomized typing against a keymap model.
// Honours PS2_KEYBOARD_FIFO_EN to select the expected buffering policy.
module tb_ps2_keyboard;

  localparam int HALF = 8;

  logic       clk25 = 1'b0;
  logic       rst, ps2_clk, ps2_data, enable, address, rd_en;
  logic [7:0] dout;
  logic       frame_err, overrun;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string digit_shifted = ")!@#$%^&*(";

  ps2_keyboard dut (
    .clk25     (clk25),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .enable    (enable),
    .address   (address),
    .rd_en     (rd_en),
    .dout      (dout),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk25 = ~clk25;

  always @(negedge clk25) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk25);
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame_of(input byte unsigned b, input bit bad_par);
    logic [7:0] v;
    v = b;
    return {1'b1, (~^v) ^ bad_par, v, 1'b0};
  endfunction

  task automatic send_byte(input byte unsigned b, input bit bad_par);
    ps2_bits(frame_of(b, bad_par), 11);
    ps2_data = 1'b1;
    cycles(4 * HALF);
  endtask

  task automatic key_up(input byte unsigned sc);
    send_byte(8'hF0, 1'b0);
    send_byte(sc, 1'b0);
  endtask

  task automatic type_key(input byte unsigned sc, input bit sh, input bit ct);
    if (sh) send_byte(8'h12, 1'b0);
    if (ct) send_byte(8'h14, 1'b0);
    send_byte(sc, 1'b0);
    key_up(sc);
    if (ct) key_up(8'h14);
    if (sh) key_up(8'h12);
  endtask

  task automatic read_reg(input logic a, output logic [7:0] d);
    @(negedge clk25);
    enable = 1'b1;
    rd_en = 1'b1;
    address = a;
    #1 d = dout;
    @(negedge clk25);
    enable = 1'b0;
    rd_en = 1'b0;
    address = 1'b0;
    @(negedge clk25);
  endtask

  task automatic expect_char(input string tag, input byte unsigned ch);
    logic [7:0] d;
    logic [7:0] want;
    want = {1'b1, ch[6:0]};
    read_reg(1'b1, d);
    check({tag, "_status_ready"}, d, 8'h80);
    read_reg(1'b0, d);
    check({tag, "_data"}, d, want);
    read_reg(1'b1, d);
    check({tag, "_status_empty"}, d, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int fe0, ov0, n, deliver, exp_ov, idx;
    bit letter, sh, ct;
    byte unsigned sc, ch;
    byte unsigned exp_q[$];

    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    enable = 1'b0;
    address = 1'b0;
    rd_en = 1'b0;
    cycles(5);
    @(negedge clk25);
    check("reset_dout", dout, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    cycles(5);
    read_reg(1'b1, d);
    check("reset_status", d, 8'h00);

    send_byte(8'h1C, 1'b0);
    expect_char("key_a", 8'h41);
    key_up(8'h1C);
    read_reg(1'b1, d);
    check("break_no_char", d, 8'h00);

    send_byte(8'h12, 1'b0);
    send_byte(8'h16, 1'b0);
    key_up(8'h16);
    key_up(8'h12);
    expect_char("shift_1", 8'h21);
    type_key(8'h16, 1'b0, 1'b0);
    expect_char("unshift_1", 8'h31);

    fe0 = fe_cnt;
    send_byte(8'h1C, 1'b1);
    check("bad_parity_err", fe_cnt - fe0, 1);
    read_reg(1'b1, d);
    check("bad_parity_not_ready", d, 8'h00);
    send_byte(8'h1C, 1'b0);
    expect_char("after_parity", 8'h41);
    key_up(8'h1C);

    fe0 = fe_cnt;
    ps2_bits(frame_of(8'h1C, 1'b0), 5);
    ps2_data = 1'b1;
    cycles(25100);
    check("timeout_err", fe_cnt - fe0, 1);
    read_reg(1'b1, d);
    check("timeout_not_ready", d, 8'h00);
    send_byte(8'h5A, 1'b0);
    expect_char("after_timeout", 8'h0D);
    key_up(8'h5A);

    type_key(8'h1C, 1'b0, 1'b1);
    expect_char("ctrl_a", 8'h01);
    type_key(8'h66, 1'b0, 1'b0);
    expect_char("backspace", 8'h5F);
    type_key(8'h76, 1'b1, 1'b0);
    expect_char("escape", 8'h1B);

    ov0 = ov_cnt;
    send_byte(8'h1C, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h21, 1'b0);
`ifdef PS2_KEYBOARD_FIFO_EN
    check("abc_overrun", ov_cnt - ov0, 0);
    read_reg(1'b0, d);
    check("abc_first", d, 8'hC1);
    read_reg(1'b0, d);
    check("abc_second", d, 8'hC2);
    read_reg(1'b0, d);
    check("abc_third", d, 8'hC3);
`else
    check("abc_overrun", ov_cnt - ov0, 2);
    read_reg(1'b0, d);
    check("abc_kept", d, 8'hC1);
`endif
    read_reg(1'b1, d);
    check("abc_drained", d, 8'h00);

    fe0 = fe_cnt;
    ps2_bits(frame_of(8'h1C, 1'b0), 6);
    @(negedge clk25);
    rst = 1'b1;
    cycles(2);
    @(negedge clk25);
    rst = 1'b0;
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    cycles(20);
    send_byte(8'h5A, 1'b0);
    expect_char("reset_midframe", 8'h0D);
    check("reset_midframe_no_err", fe_cnt - fe0, 0);

    fe0 = fe_cnt;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      exp_q.delete();
      ov0 = ov_cnt;
      for (int k = 0; k < n; k++) begin
        letter = 1'($urandom_range(0, 1));
        sh = 1'($urandom_range(0, 1));
        ct = 1'($urandom_range(0, 1));
        if (letter) begin
          idx = $urandom_range(0, 25);
          sc = letter_sc[idx];
          ch = 8'h41 + 8'(idx);
          if (ct) ch = ch & 8'h1F;
        end else begin
          idx = $urandom_range(0, 9);
          sc = digit_sc[idx];
          ch = sh ? digit_shifted[idx] : 8'h30 + 8'(idx);
        end
        type_key(sc, sh, ct);
        exp_q.push_back(ch);
      end
`ifdef PS2_KEYBOARD_FIFO_EN
      deliver = (n > 4) ? 4 : n;
      exp_ov = (n > 4) ? n - 4 : 0;
`else
      deliver = 1;
      exp_ov = n - 1;
`endif
      check($sformatf("rand%0d_overrun", it), ov_cnt - ov0, exp_ov);
      for (int k = 0; k < deliver; k++) begin
        ch = exp_q[k];
        read_reg(1'b0, d);
        check($sformatf("rand%0d_char%0d", it, k), d, {1'b1, ch[6:0]});
      end
      read_reg(1'b1, d);
      check($sformatf("rand%0d_drained", it), d, 8'h00);
    end
    check("rand_no_frame_err", fe_cnt - fe0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
